// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed scan controller for a 4-digit FND display.
// It walks a slot index through the numeral slots (0-3) and, optionally, the
// dot slots (4-7). Each slot lasts DIV clock cycles and begins with a short
// blanking window so that the previous digit does not ghost onto the next one.
module fnd_scan_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 8_000,
    parameter int BLANK_CYC = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_dotSkip,
    output logic [2:0] o_digitPosition,
    output logic [3:0] o_fndCom,
    output logic       o_slotTick
);

    // Cycles per slot and the width of the prescaler that counts them.
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYC);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_next;
    logic [2:0]    position;
    logic [2:0]    position_next;
    logic          slot_end;

    // The last prescaler count of a slot while scanning is the slot tick.
    assign slot_end = (state == SCAN) && (prescaler == PRESC_LAST);

    // State, prescaler and slot index registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            prescaler <= '0;
            position  <= 3'd0;
        end else begin
            state     <= state_next;
            prescaler <= prescaler_next;
            position  <= position_next;
        end
    end

    // Next-state logic: enable drop wins over a coincident slot tick, and
    // i_dotSkip is only looked at when the slot index actually advances.
    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        position_next  = position;
        case (state)
            IDLE: begin
                prescaler_next = '0;
                position_next  = 3'd0;
                if (i_en) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!i_en) begin
                    state_next     = IDLE;
                    prescaler_next = '0;
                    position_next  = 3'd0;
                end else if (slot_end) begin
                    prescaler_next = '0;
                    if (i_dotSkip) begin
                        position_next = (position >= 3'd3) ? 3'd0 : 3'(position + 3'd1);
                    end else begin
                        position_next = 3'(position + 3'd1);
                    end
                end else begin
                    prescaler_next = PW'(prescaler + 1'b1);
                end
            end
            default: begin
                state_next     = IDLE;
                prescaler_next = '0;
                position_next  = 3'd0;
            end
        endcase
    end

    // Output decode: commons stay off outside SCAN and during blanking;
    // otherwise exactly one common selected by the low two slot bits.
    always_comb begin
        o_fndCom   = 4'b1111;
        o_slotTick = slot_end;
        if ((state == SCAN) && (prescaler >= PRESC_BLANK)) begin
            case (position[1:0])
                2'd0:    o_fndCom = 4'b1110;
                2'd1:    o_fndCom = 4'b1101;
                2'd2:    o_fndCom = 4'b1011;
                default: o_fndCom = 4'b0111;
            endcase
        end
    end

    assign o_digitPosition = position;

endmodule
